xif_result_buffer: RTL and testbench
====================================

Name: xif_result_buffer

Overview:
- Sits on the XIF result path between the Spatz vector unit (producer) and the CVE2 result interface (consumer).
- Spatz runs with unregistered responses, so this block provides a Depth-entry result FIFO that decouples Spatz rsp_valid/rsp_ready timing from CVE2 writeback.
- It also snoops the XIF issue handshake and keeps a pending-writeback scoreboard per scalar register, so CVE2 can stall on RAW hazards against vector results that are still in flight.

Parameters:
- Depth, 4, FIFO entries; power of two, >= 2.
- FallThrough, 0, 1 = when empty, a pushed result is presented on out_* in the same cycle.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- issue_valid_i  in  1  XIF issue valid (snooped)
- issue_ready_i  in  1  XIF issue ready (snooped)
- issue_accept_i  in  1  Spatz accepted the instruction
- issue_writeback_i  in  1  accepted instruction will write a scalar rd
- issue_rd_i  in  5  instr[11:7] of the issued instruction
- in_valid_i  in  1  Spatz result valid
- in_ready_o  out  1  buffer can accept a result
- in_rd_i  in  5  result destination register
- in_we_i  in  1  result write enable
- in_err_i  in  1  result error
- in_data_i  in  32  result data
- out_valid_o  out  1  result valid to CVE2
- out_ready_i  in  1  CVE2 result ready
- out_rd_o  out  5  result destination register
- out_we_o  out  1  result write enable
- out_err_o  out  1  result error
- out_data_o  out  32  result data
- level_o  out  $clog2(Depth)+1  FIFO occupancy
- pending_o  out  32  bit r = writeback to xr pending
- sb_err_o  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, level_o=0, out_valid_o=0, out_* payload=0, in_ready_o=0 while in reset then 1, pending_o=0, sb_err_o=0. Reset mid-transfer drops all entries.
- Push: occurs when in_valid_i & in_ready_o. in_ready_o = (level_o != Depth); registered, no dependence on out_ready_i.
  - When full, no push in that cycle even if a pop occurs.
- Pop: occurs when out_valid_o & out_ready_i. out_valid_o = (level_o != 0), or, with FallThrough=1, also in_valid_i when empty.
- Ordering is strict FIFO. Read/write pointers are log2(Depth) bits and wrap modulo Depth; full/empty come from the level counter.
- Simultaneous push and pop with 0 < level < Depth: level unchanged.
- FallThrough=1 and empty with push and pop in the same cycle: in_* is passed combinationally to out_*, nothing is stored, level stays 0.
- FallThrough=0: minimum latency is push to out_valid_o one cycle later.
- Payload is held stable while out_valid_o & !out_ready_i. out_* payload shows the head entry; otherwise it holds its last value.
- Scoreboard set: issue_valid_i & issue_ready_i & issue_accept_i & issue_writeback_i & (issue_rd_i != 0) sets pending[rd] on the next edge.
- Scoreboard clear: a pop with out_we_o & (out_rd_o != 0) clears pending[out_rd_o].
- Set and clear of the same rd in one cycle: set wins, bit stays 1.
- pending_o[0] is always 0.
- sb_err_o is set, and held until reset, when:
  - a set targets an already-pending bit (not counting a same-cycle clear of that rd), or
  - a clear targets a non-pending bit.
  - In both cases the bit update still follows the rules above.
- Arithmetic: level update is level + push - pop, always within 0..Depth; no overflow is possible because of the in_ready_o gating.

Decomposition:
- Shared package cve2v_xif_pkg holds:
  - typedef xif_result_t (rd[4:0], we, err, data[31:0]), packed, 39 bits;
  - constant XifNumRegs = 32.
- One sub-module, cve2v_sync_fifo: parameters Depth, FallThrough, type T; ports valid/ready in and out plus level. This block instantiates it with T = xif_result_t.
- The scoreboard logic stays in xif_result_buffer.

Test Plan:
- Reset, then 4 back-to-back results rd=1..4, data=0x10..0x13, out_ready_i=0 -> level_o=4, in_ready_o=0. A 5th push is stalled. Raising out_ready_i pops 0x10..0x13 in order, level returns to 0.
- FallThrough=1, empty, push rd=5 data=0xDEADBEEF with out_ready_i=1 -> out_valid_o and the data appear in the same cycle, level_o stays 0.
- FallThrough=0, level=2, push and pop every cycle for 10 cycles -> level stays 2, all data is in order, pointers wrap with no loss.
- Issue accept with writeback, rd=7 -> pending_o=0x80. Popping a result with rd=7, we=1 clears it. Issuing rd=0 -> pending_o stays 0.
- Same cycle: issue rd=3 set and pop of a result rd=3, we=1 -> pending_o[3]=1, sb_err_o=0 (given bit 3 was pending before).
- Pop of a result rd=9, we=1 with pending[9]=0 -> sb_err_o=1 and it stays 1 until rst_ni is asserted. Asserting rst_ni with 3 entries queued -> level_o=0, out_valid_o=0, pending_o=0.

Source files
------------

// File: rtl/cve2v_xif_pkg.sv
// Shared XIF result-path types for the CVE2/Spatz coupling.
package cve2v_xif_pkg;

  localparam int XifNumRegs = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        err;
    logic [31:0] data;
  } xif_result_t;

endpackage

// File: rtl/cve2v_sync_fifo.sv
// Synchronous valid/ready FIFO with a level counter, registered ready
// and an optional empty fall-through path.
module cve2v_sync_fifo #(
  parameter int  Depth       = 4,
  parameter bit  FallThrough = 1'b0,
  parameter type T           = logic
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  T                       data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output T                       data_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int LvlW = PtrW + 1;

  T                r_mem [Depth];
  T                r_head;
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [LvlW-1:0] r_level;
  logic            r_ready;

  logic            w_empty;
  logic            w_push;
  logic            w_bypass;
  logic            w_pop;
  logic            w_store;
  logic            w_deq;
  logic [LvlW-1:0] w_level_nxt;
  logic [LvlW-1:0] w_remain;
  logic [PtrW-1:0] w_rptr_nxt;
  T                w_head_nxt;

  assign w_empty  = (r_level == '0);
  assign w_push   = valid_i & r_ready;
  // A result pushed into an empty buffer is visible immediately only in fall-through mode.
  assign w_bypass = FallThrough & w_empty & w_push;
  assign valid_o  = ~w_empty | w_bypass;
  assign w_pop    = valid_o & ready_i;
  assign w_store  = w_push & ~(w_bypass & w_pop);
  assign w_deq    = w_pop & ~w_empty;

  assign w_remain    = r_level - LvlW'(w_deq);
  assign w_level_nxt = w_remain + LvlW'(w_store);
  assign w_rptr_nxt  = r_rptr + PtrW'(w_deq);

  // The head register tracks whatever sits at the read pointer after this edge.
  always_comb begin
    w_head_nxt = r_head;
    if (w_level_nxt != '0) begin
      w_head_nxt = (w_store && (w_remain == '0)) ? data_i : r_mem[w_rptr_nxt];
    end else if (w_bypass) begin
      w_head_nxt = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store) r_mem[r_wptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
      r_head  <= T'('0);
    end else begin
      r_wptr  <= r_wptr + PtrW'(w_store);
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LvlW'(Depth));
      r_head  <= w_head_nxt;
    end
  end

  assign ready_o = r_ready;
  assign data_o  = w_bypass ? data_i : r_head;
  assign level_o = r_level;

endmodule

// File: rtl/xif_result_buffer.sv
// XIF result buffer: decouples Spatz results from CVE2 writeback and tracks
// scalar registers with vector writebacks still in flight.
module xif_result_buffer
  import cve2v_xif_pkg::*;
#(
  parameter int Depth       = 4,
  parameter bit FallThrough = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic                   issue_ready_i,
  input  logic                   issue_accept_i,
  input  logic                   issue_writeback_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [4:0]             in_rd_i,
  input  logic                   in_we_i,
  input  logic                   in_err_i,
  input  logic [31:0]            in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [4:0]             out_rd_o,
  output logic                   out_we_o,
  output logic                   out_err_o,
  output logic [31:0]            out_data_o,
  output logic [$clog2(Depth):0] level_o,
  output logic [XifNumRegs-1:0]  pending_o,
  output logic                   sb_err_o
);

  xif_result_t           w_in;
  xif_result_t           w_out;
  logic                  w_pop;
  logic                  w_set;
  logic                  w_clr;
  logic                  w_err;
  logic [XifNumRegs-1:0] w_pend_nxt;
  logic [XifNumRegs-1:0] r_pend;
  logic                  r_sb_err;

  assign w_in = '{rd: in_rd_i, we: in_we_i, err: in_err_i, data: in_data_i};

  cve2v_sync_fifo #(
    .Depth       (Depth),
    .FallThrough (FallThrough),
    .T           (xif_result_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (in_valid_i),
    .ready_o (in_ready_o),
    .data_i  (w_in),
    .valid_o (out_valid_o),
    .ready_i (out_ready_i),
    .data_o  (w_out),
    .level_o (level_o)
  );

  assign out_rd_o   = w_out.rd;
  assign out_we_o   = w_out.we;
  assign out_err_o  = w_out.err;
  assign out_data_o = w_out.data;

  assign w_pop = out_valid_o & out_ready_i;
  assign w_set = issue_valid_i & issue_ready_i & issue_accept_i & issue_writeback_i
               & (issue_rd_i != 5'd0);
  assign w_clr = w_pop & out_we_o & (out_rd_o != 5'd0);

  // Set is applied after clear so a same-cycle issue keeps the register pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr) w_pend_nxt[out_rd_o] = 1'b0;
    if (w_set) w_pend_nxt[issue_rd_i] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  assign w_err = (w_set & r_pend[issue_rd_i] & ~(w_clr & (out_rd_o == issue_rd_i)))
               | (w_clr & ~r_pend[out_rd_o]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_sb_err <= r_sb_err | w_err;
    end
  end

  assign pending_o = r_pend;
  assign sb_err_o  = r_sb_err;

endmodule

// File: tb/tb_xif_result_buffer.sv
// Bench for xif_result_buffer: directed scenarios on both FIFO modes plus a
// randomized run against a queue-based reference model.
module tb_xif_result_buffer;
  import cve2v_xif_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // FallThrough=0 instance
  logic        is_v = 0, is_r = 0, is_a = 0, is_wb = 0;
  logic [4:0]  is_rd = 0;
  logic        iv = 0, iwe = 0, ierr = 0, ordy = 0;
  logic [4:0]  ird = 0;
  logic [31:0] idata = 0;
  logic        in_rdy, ov, owe, oerr, sberr;
  logic [4:0]  ord;
  logic [31:0] odata, pend;
  logic [2:0]  lvl;

  // FallThrough=1 instance
  logic        f_iv = 0, f_ordy = 0;
  logic [4:0]  f_ird = 0;
  logic [31:0] f_idata = 0;
  logic        f_in_rdy, f_ov, f_owe, f_oerr, f_sberr;
  logic [4:0]  f_ord;
  logic [31:0] f_odata, f_pend;
  logic [2:0]  f_lvl;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  xif_result_t q[$];
  logic [31:0] m_pend;
  logic        m_err;

  xif_result_buffer #(.Depth(4), .FallThrough(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(is_v), .issue_ready_i(is_r), .issue_accept_i(is_a),
    .issue_writeback_i(is_wb), .issue_rd_i(is_rd),
    .in_valid_i(iv), .in_ready_o(in_rdy), .in_rd_i(ird), .in_we_i(iwe),
    .in_err_i(ierr), .in_data_i(idata),
    .out_valid_o(ov), .out_ready_i(ordy), .out_rd_o(ord), .out_we_o(owe),
    .out_err_o(oerr), .out_data_o(odata),
    .level_o(lvl), .pending_o(pend), .sb_err_o(sberr)
  );

  xif_result_buffer #(.Depth(4), .FallThrough(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(1'b0), .issue_ready_i(1'b0), .issue_accept_i(1'b0),
    .issue_writeback_i(1'b0), .issue_rd_i(5'd0),
    .in_valid_i(f_iv), .in_ready_o(f_in_rdy), .in_rd_i(f_ird), .in_we_i(1'b0),
    .in_err_i(1'b0), .in_data_i(f_idata),
    .out_valid_o(f_ov), .out_ready_i(f_ordy), .out_rd_o(f_ord), .out_we_o(f_owe),
    .out_err_o(f_oerr), .out_data_o(f_odata),
    .level_o(f_lvl), .pending_o(f_pend), .sb_err_o(f_sberr)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model transition for one clock edge, derived from the FIFO/scoreboard rules.
  task automatic model_step(input bit push, input bit pop, input xif_result_t item,
                            input bit set, input logic [4:0] srd);
    bit clr;
    logic [4:0] crd;
    clr = 0; crd = 0;
    if (pop) begin
      crd = q[0].rd;
      clr = q[0].we && (crd != 0);
    end
    set = set && (srd != 0);
    if (set && m_pend[srd] && !(clr && crd == srd)) m_err = 1;
    if (clr && !m_pend[crd]) m_err = 1;
    if (clr) m_pend[crd] = 0;
    if (set) m_pend[srd] = 1;
    m_pend[0] = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(item);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_checks++; if (lvl !== 3'd0) begin n_errors++; $display("FAIL reset_level: got %0d want 0", lvl); end
    n_checks++; if (ov !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", ov); end
    n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b want 0", in_rdy); end
    n_checks++; if (odata !== 32'd0 || ord !== 5'd0) begin n_errors++; $display("FAIL reset_payload: got %h/%0d want 0/0", odata, ord); end
    n_checks++; if (pend !== 32'd0 || sberr !== 1'b0) begin n_errors++; $display("FAIL reset_sb: got %h/%b want 0/0", pend, sberr); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    n_checks++; if (in_rdy !== 1'b1 || f_in_rdy !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready: got %b/%b want 1/1", in_rdy, f_in_rdy); end
  endtask

  task automatic test_fill_drain();
    ordy = 0;
    for (int i = 0; i < 4; i++) begin
      iv = 1; ird = 5'(i + 1); iwe = 0; idata = 32'h10 + i;
      tick();
    end
    n_checks++; if (lvl !== 3'd4) begin n_errors++; $display("FAIL full_level: got %0d want 4", lvl); end
    n_checks++; if (in_rdy !== 1'b0) begin n_errors++; $display("FAIL full_in_ready: got %b want 0", in_rdy); end
    idata = 32'h14; ird = 5;
    tick();
    n_checks++; if (lvl !== 3'd4) begin n_errors++; $display("FAIL stalled_push: got level %0d want 4", lvl); end
    iv = 0; ordy = 1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ov !== 1'b1 || odata !== 32'h10 + i || ord !== 5'(i + 1)) begin
        n_errors++; $display("FAIL drain_%0d: got v=%b d=%h rd=%0d want v=1 d=%h rd=%0d", i, ov, odata, ord, 32'h10 + i, i + 1);
      end
      tick();
    end
    n_checks++; if (lvl !== 3'd0 || ov !== 1'b0) begin n_errors++; $display("FAIL drained: got level %0d v=%b want 0/0", lvl, ov); end
    ordy = 0;
  endtask

  task automatic test_fallthrough();
    f_iv = 1; f_ird = 5; f_idata = 32'hDEADBEEF; f_ordy = 1;
    #1;
    n_checks++; if (f_ov !== 1'b1 || f_odata !== 32'hDEADBEEF || f_ord !== 5'd5) begin n_errors++; $display("FAIL ft_same_cycle: got v=%b d=%h rd=%0d want 1/deadbeef/5", f_ov, f_odata, f_ord); end
    tick();
    f_iv = 0;
    #1;
    n_checks++; if (f_lvl !== 3'd0 || f_ov !== 1'b0) begin n_errors++; $display("FAIL ft_nothing_stored: got level %0d v=%b want 0/0", f_lvl, f_ov); end
    f_iv = 1; f_idata = 32'h00C0FFEE; f_ordy = 0;
    tick();
    f_iv = 0;
    n_checks++; if (f_lvl !== 3'd1 || f_ov !== 1'b1 || f_odata !== 32'h00C0FFEE) begin n_errors++; $display("FAIL ft_stored: got level %0d v=%b d=%h want 1/1/00c0ffee", f_lvl, f_ov, f_odata); end
    f_ordy = 1;
    tick();
    f_ordy = 0;
    n_checks++; if (f_lvl !== 3'd0) begin n_errors++; $display("FAIL ft_pop: got level %0d want 0", f_lvl); end
  endtask

  task automatic test_back_to_back();
    xif_result_t it;
    q.delete();
    ordy = 0;
    for (int i = 0; i < 2; i++) begin
      it = '{rd: 5'($urandom_range(1, 31)), we: 1'b0, err: 1'($urandom), data: $urandom};
      iv = 1; ird = it.rd; iwe = 0; ierr = it.err; idata = it.data;
      q.push_back(it);
      tick();
    end
    ordy = 1;
    for (int c = 0; c < 10; c++) begin
      it = '{rd: 5'($urandom_range(1, 31)), we: 1'b0, err: 1'($urandom), data: $urandom};
      ird = it.rd; ierr = it.err; idata = it.data;
      #1;
      n_checks++;
      if (lvl !== 3'd2 || {ord, owe, oerr, odata} !== q[0]) begin
        n_errors++; $display("FAIL b2b_%0d: got level %0d d=%h want 2/%h", c, lvl, odata, q[0].data);
      end
      void'(q.pop_front());
      q.push_back(it);
      @(posedge clk); #1;
    end
    iv = 0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ord, owe, oerr, odata} !== q[0]) begin n_errors++; $display("FAIL b2b_tail_%0d: got %h want %h", i, odata, q[0].data); end
      void'(q.pop_front());
      tick();
    end
    ordy = 0;
    n_checks++; if (lvl !== 3'd0) begin n_errors++; $display("FAIL b2b_empty: got level %0d want 0", lvl); end
  endtask

  task automatic test_scoreboard();
    is_v = 1; is_r = 1; is_a = 1; is_wb = 1; is_rd = 7;
    tick();
    is_v = 0;
    n_checks++; if (pend !== 32'h80) begin n_errors++; $display("FAIL sb_set7: got %h want 00000080", pend); end
    iv = 1; ird = 7; iwe = 1; idata = 32'h77;
    tick();
    iv = 0; ordy = 1;
    tick();
    ordy = 0;
    n_checks++; if (pend !== 32'h0 || sberr !== 1'b0) begin n_errors++; $display("FAIL sb_clr7: got %h/%b want 0/0", pend, sberr); end
    is_v = 1; is_rd = 0;
    tick();
    is_v = 0;
    n_checks++; if (pend !== 32'h0) begin n_errors++; $display("FAIL sb_rd0: got %h want 0", pend); end
  endtask

  task automatic test_same_cycle();
    is_v = 1; is_rd = 3;
    tick();
    is_v = 0;
    iv = 1; ird = 3; iwe = 1; idata = 32'h33;
    tick();
    iv = 0;
    is_v = 1; is_rd = 3; ordy = 1;
    tick();
    is_v = 0; ordy = 0;
    n_checks++; if (pend !== 32'h08 || sberr !== 1'b0) begin n_errors++; $display("FAIL sb_same_cycle: got %h/%b want 00000008/0", pend, sberr); end
  endtask

  task automatic test_sb_err_and_reset();
    iv = 1; ird = 9; iwe = 1; idata = 32'h99;
    tick();
    iv = 0; ordy = 1;
    tick();
    ordy = 0;
    n_checks++; if (sberr !== 1'b1 || pend !== 32'h08) begin n_errors++; $display("FAIL sb_err_set: got %b/%h want 1/00000008", sberr, pend); end
    repeat (3) tick();
    n_checks++; if (sberr !== 1'b1) begin n_errors++; $display("FAIL sb_err_sticky: got %b want 1", sberr); end
    for (int i = 0; i < 3; i++) begin
      iv = 1; ird = 5'(i + 1); iwe = 0; idata = 32'hA0 + i;
      tick();
    end
    iv = 0;
    n_checks++; if (lvl !== 3'd3) begin n_errors++; $display("FAIL pre_reset_level: got %0d want 3", lvl); end
    rst_n = 0;
    #1;
    n_checks++; if (lvl !== 3'd0 || ov !== 1'b0 || pend !== 32'h0 || sberr !== 1'b0) begin n_errors++; $display("FAIL mid_reset: got level %0d v=%b pend=%h err=%b want 0/0/0/0", lvl, ov, pend, sberr); end
    @(posedge clk); #1 rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    xif_result_t it;
    bit push, pop, set;
    q.delete(); m_pend = '0; m_err = 0;
    for (int c = 0; c < 300; c++) begin
      it = '{rd: 5'($urandom_range(0, 7)), we: 1'($urandom), err: 1'($urandom), data: $urandom};
      iv = 1'($urandom); ird = it.rd; iwe = it.we; ierr = it.err; idata = it.data;
      ordy = ($urandom_range(0, 3) != 0);
      is_v = 1'($urandom); is_r = 1'($urandom); is_a = ($urandom_range(0, 3) != 0);
      is_wb = 1'($urandom); is_rd = 5'($urandom_range(0, 7));
      #1;
      n_checks++; if (lvl !== 3'(q.size())) begin n_errors++; $display("FAIL rnd_level_%0d: got %0d want %0d", c, lvl, q.size()); end
      n_checks++; if (in_rdy !== (q.size() != 4)) begin n_errors++; $display("FAIL rnd_in_ready_%0d: got %b want %b", c, in_rdy, q.size() != 4); end
      n_checks++; if (ov !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid_%0d: got %b want %b", c, ov, q.size() != 0); end
      if (q.size() != 0) begin
        n_checks++; if ({ord, owe, oerr, odata} !== q[0]) begin n_errors++; $display("FAIL rnd_payload_%0d: got %h want %h", c, {ord, owe, oerr, odata}, q[0]); end
      end
      n_checks++; if (pend !== m_pend) begin n_errors++; $display("FAIL rnd_pending_%0d: got %h want %h", c, pend, m_pend); end
      n_checks++; if (sberr !== m_err) begin n_errors++; $display("FAIL rnd_sb_err_%0d: got %b want %b", c, sberr, m_err); end
      push = iv && (q.size() != 4);
      pop  = ordy && (q.size() != 0);
      set  = is_v && is_r && is_a && is_wb;
      model_step(push, pop, it, set, is_rd);
      @(posedge clk); #1;
    end
    iv = 0; ordy = 0; is_v = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_fallthrough();
    test_back_to_back();
    test_scoreboard();
    test_same_cycle();
    test_sb_err_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
